// File: rtl/c7b_memarb_pkg.sv
// Shared types and constants for the c7b memory arbiter.
package c7b_memarb_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StResp = 2'd2
    } state_e;

    typedef enum logic {
        OwnIfu = 1'b0,
        OwnLsu = 1'b1
    } owner_e;

    localparam int unsigned CntW = 4;

endpackage

// File: rtl/c7b_memarb_sel.sv
// Winner selection between IFU and LSU with the IFU anti-starvation counter.
module c7b_memarb_sel
    import c7b_memarb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_idle,
    input  logic            ifu_req,
    input  logic            ifu_cancel,
    input  logic            lsu_req,
    output logic            grant_ifu,
    output logic            grant_lsu,
    output logic [CntW-1:0] starve_cnt
);

    localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            ifu_elig;
    logic            force_ifu;

    assign ifu_elig   = ifu_req & ~ifu_cancel;
    assign force_ifu  = ifu_elig & (cnt_q == Limit);
    assign grant_lsu  = in_idle & lsu_req & ~force_ifu;
    assign grant_ifu  = in_idle & ifu_elig & (~lsu_req | force_ifu);
    assign starve_cnt = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (grant_ifu) begin
            cnt_d = '0;
        end else if (grant_lsu && ifu_req) begin
            cnt_d = (cnt_q == Limit) ? cnt_q : cnt_q + 1'b1;
        end else if (in_idle && !ifu_req) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/c7b_memarb.sv
// Single-outstanding arbiter of the IFU fetch port and LSU data port onto one memory bus.
module c7b_memarb
    import c7b_memarb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ifu_req,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_ack,
    input  logic                ifu_cancel,
    output logic                ifu_data_vld,
    output logic [DATA_W-1:0]   ifu_data,
    input  logic                lsu_req,
    input  logic                lsu_wr,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wstrb,
    output logic                lsu_ack,
    output logic                lsu_data_vld,
    output logic [DATA_W-1:0]   lsu_data,
    output logic                bus_req,
    output logic                bus_wr,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    output logic [DATA_W/8-1:0] bus_wstrb,
    input  logic                bus_ack,
    input  logic                bus_rvalid,
    input  logic [DATA_W-1:0]   bus_rdata
);

    state_e                state_q, state_d;
    owner_e                owner_q, owner_d;
    logic                  drop_q, drop_d;
    logic                  wr_q, wr_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;
    logic                  grant_ifu, grant_lsu;
    logic [CntW-1:0]       starve_cnt;
    logic                  rsp_vld;

    c7b_memarb_sel #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_sel (
        .clk        (clk),
        .reset      (reset),
        .in_idle    (state_q == StIdle),
        .ifu_req    (ifu_req),
        .ifu_cancel (ifu_cancel),
        .lsu_req    (lsu_req),
        .grant_ifu  (grant_ifu),
        .grant_lsu  (grant_lsu),
        .starve_cnt (starve_cnt)
    );

    // Responses outside an accepted transaction are protocol violations and ignored.
    assign rsp_vld = bus_rvalid & (((state_q == StReq) & bus_ack) | (state_q == StResp));

    assign ifu_ack      = grant_ifu;
    assign lsu_ack      = grant_lsu;
    assign ifu_data_vld = rsp_vld & (owner_q == OwnIfu) & ~drop_q & ~ifu_cancel;
    assign lsu_data_vld = rsp_vld & (owner_q == OwnLsu);
    assign ifu_data     = bus_rdata;
    assign lsu_data     = bus_rdata;
    assign bus_req      = (state_q == StReq);
    assign bus_wr       = wr_q;
    assign bus_addr     = addr_q;
    assign bus_wdata    = wdata_q;
    assign bus_wstrb    = wstrb_q;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        drop_d  = drop_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        unique case (state_q)
            StIdle: begin
                if (grant_lsu) begin
                    state_d = StReq;
                    owner_d = OwnLsu;
                    wr_d    = lsu_wr;
                    addr_d  = lsu_addr;
                    wdata_d = lsu_wdata;
                    wstrb_d = lsu_wstrb;
                end else if (grant_ifu) begin
                    state_d = StReq;
                    owner_d = OwnIfu;
                    wr_d    = 1'b0;
                    addr_d  = ifu_addr;
                    wdata_d = '0;
                    wstrb_d = '0;
                end
            end
            StReq: begin
                if (ifu_cancel && owner_q == OwnIfu) drop_d = 1'b1;
                if (bus_ack) state_d = bus_rvalid ? StIdle : StResp;
            end
            StResp: begin
                if (ifu_cancel && owner_q == OwnIfu) drop_d = 1'b1;
                if (bus_rvalid) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (state_d == StIdle) drop_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            owner_q <= OwnIfu;
            drop_q  <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            drop_q  <= drop_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
        end
    end

endmodule

// File: doc/c7b_memarb.md
Name: c7b_memarb

Overview:
- Arbitrates between the IFU fetch port (ic1/ic2 request/ack/data-valid protocol) and the LSU data port for a single shared memory bus.
- Sits between c7bifu / LSU and the bus interface.
- Serialises one outstanding transaction at a time.
- Enforces LSU priority with an IFU anti-starvation limit.
- Silently drops fetch data for IFU transactions cancelled by a pipeline flush.

Parameters:
ADDR_W, 32, address width.
DATA_W, 64, data width; wstrb width is DATA_W/8.
STARVE_LIMIT, 4, consecutive LSU grants while IFU waits before IFU is forced to win; legal range 1..15.

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
ifu_req  in  1  fetch request; held with stable ifu_addr until ifu_ack
ifu_addr  in  ADDR_W  fetch address
ifu_ack  out  1  one-cycle pulse: fetch request accepted
ifu_cancel  in  1  flush: discard any in-flight or just-accepted fetch
ifu_data_vld  out  1  fetch data valid pulse
ifu_data  out  DATA_W  fetch data
lsu_req  in  1  load/store request; held stable until lsu_ack
lsu_wr  in  1  1 = store
lsu_addr  in  ADDR_W  address
lsu_wdata  in  DATA_W  store data
lsu_wstrb  in  DATA_W/8  byte strobes
lsu_ack  out  1  one-cycle pulse: request accepted
lsu_data_vld  out  1  load data / store completion pulse
lsu_data  out  DATA_W  load data
bus_req  out  1  bus request, held until bus_ack
bus_wr  out  1  store indicator
bus_addr  out  ADDR_W  registered address
bus_wdata  out  DATA_W  registered store data
bus_wstrb  out  DATA_W/8  registered strobes
bus_ack  in  1  bus accepted request
bus_rvalid  in  1  response (read data or write completion)
bus_rdata  in  DATA_W  read data

Behaviour:
- Reset (async, any state): state=IDLE, owner=IFU, drop=0, starve_cnt=0. All outputs 0, including bus_addr/wdata/wstrb. A transaction in flight at reset is abandoned; any bus_rvalid after reset is ignored.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - IFU is eligible iff ifu_req & ~ifu_cancel.
  - Winner selection: LSU wins if lsu_req, unless IFU is eligible and starve_cnt==STARVE_LIMIT, in which case IFU wins. Otherwise IFU wins if eligible.
  - On a win: pulse the winner's ack in this cycle; latch addr/wr/wdata/wstrb into the bus registers (IFU forces wr=0, wstrb=0); set owner; clear drop; next state REQ.
- REQ:
  - bus_req=1 with registered fields.
  - On bus_ack: go to RESP. If bus_rvalid arrives in the same cycle, deliver the response and go directly to IDLE.
- RESP:
  - Wait for bus_rvalid, deliver the response, then next state IDLE.
  - Minimum request-to-request spacing is 3 cycles (IDLE, REQ, RESP with a 1-cycle bus).
- Response delivery is combinational, zero latency:
  - ifu_data_vld = bus_rvalid & owner==IFU & ~drop & ~ifu_cancel.
  - lsu_data_vld = bus_rvalid & owner==LSU.
  - Data outputs mirror bus_rdata ungated.
- Cancel:
  - ifu_cancel in REQ/RESP with owner==IFU sets drop. The bus transaction still completes; its data is suppressed.
  - drop clears on return to IDLE.
  - Cancel in IDLE only blocks the IFU from winning that cycle.
  - Cancel has no effect on LSU transactions.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on each LSU grant while ifu_req=1.
  - Clears on any IFU grant, or in any IDLE cycle with ifu_req=0.
- bus_rvalid in IDLE or in REQ without bus_ack is a protocol violation: ignored and asserted against in verification.
- Requesters must not drop req before ack; behaviour is undefined otherwise, except for ifu_cancel as specified.

Decomposition:
- Package c7b_memarb_pkg:
  - state encoding (IDLE/REQ/RESP, 2 bits)
  - owner encoding (OWN_IFU=0, OWN_LSU=1)
  - counter width constant (4 bits)
- Sub-module c7b_memarb_sel: combinational winner select plus the starve_cnt register.
- Top module holds the FSM, bus registers and response routing.

Test Plan:
- Reset during RESP with an IFU read pending -> outputs 0 next edge; a later bus_rvalid=1, rdata=0xDEAD produces no ifu_data_vld.
- ifu_req addr 0x1c000000 alone, bus acks at cycle 2 and rvalid with 0x0123456789abcdef at cycle 4 -> ifu_ack at cycle 0, bus_req cycles 1-2, bus_addr=0x1c000000, ifu_data_vld at cycle 4 with that data.
- lsu_req and ifu_req both asserted from cycle 0 -> LSU wins; LSU is re-requested every IDLE; IFU is granted on the 5th grant (STARVE_LIMIT=4); starve_cnt returns to 0.
- LSU store addr 0x80, wdata 0xAA.., wstrb 0x0F -> bus_wr=1 with identical fields; lsu_data_vld pulses on bus_rvalid.
- IFU fetch in RESP, ifu_cancel pulsed 1 cycle -> rvalid arrives, ifu_data_vld stays 0; next IFU request is granted normally.
- bus_ack and bus_rvalid in the same REQ cycle -> data delivered that cycle; FSM in IDLE next cycle; a queued LSU request is acked there.
